// File: rtl/operand_fetch_pkg.sv
// Shared types for the operand fetch stage: the decoded instruction view it
// consumes, the register index width, and the fetch FSM state encoding.
package operand_fetch_pkg;

    // Register index width for a 32-entry bank
    localparam int REG_IDX_W = 5;

    // Fields of a decoded instruction that operand fetch cares about
    typedef struct packed {
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic [REG_IDX_W-1:0] rd;
        logic                 rs1_is_freg;
        logic                 rs2_is_freg;
        logic                 writes_to_freg_as_rv32f;
        logic                 writes_rd;
    } instructions;

    // Fetch FSM: IDLE accepts requests, WAIT holds a request with a pending source
    typedef enum logic {
        OF_IDLE = 1'b0,
        OF_WAIT = 1'b1
    } of_state_t;

endpackage

// File: rtl/operand_fetch_regbank.sv
// One register bank: single write port and two asynchronous read ports with
// write-to-read bypass. ZERO_REG0 turns entry 0 into a hardwired zero.
module operand_fetch_regbank #(
    parameter int NREGS     = 32,
    parameter int XLEN      = 32,
    parameter bit ZERO_REG0 = 1'b1,
    localparam int IDX_W    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [XLEN-1:0]  i_wdata,
    input  logic [IDX_W-1:0] i_raddr1,
    input  logic [IDX_W-1:0] i_raddr2,
    output logic [XLEN-1:0]  o_rdata1,
    output logic [XLEN-1:0]  o_rdata2
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wrAllowed;

    // A write to the hardwired-zero entry is dropped entirely
    assign w_wrAllowed = i_we && !(ZERO_REG0 && (i_waddr == '0));

    // Storage update: synchronous clear of every entry, then single-port writes
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wrAllowed) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Read ports: zero entry first, then same-cycle write bypass, then array
    always_comb begin
        o_rdata1 = r_regs[i_raddr1];
        o_rdata2 = r_regs[i_raddr2];
        if (w_wrAllowed && (i_waddr == i_raddr1)) o_rdata1 = i_wdata;
        if (w_wrAllowed && (i_waddr == i_raddr2)) o_rdata2 = i_wdata;
        if (ZERO_REG0 && (i_raddr1 == '0)) o_rdata1 = '0;
        if (ZERO_REG0 && (i_raddr2 == '0)) o_rdata2 = '0;
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: owns the integer and float register banks, accepts
// write-back writes, tracks in-flight destinations in a pending scoreboard and
// hands rs1/rs2 to execute once neither source is still being produced.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int XLEN  = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enabled,
    input  instructions          instr,
    input  logic                 reg_w_enable,
    input  logic                 freg_w_enable,
    input  logic [REG_IDX_W-1:0] reg_w_dest,
    input  logic [XLEN-1:0]      reg_w_data,
    output logic                 completed,
    output logic [XLEN-1:0]      rs1_data,
    output logic [XLEN-1:0]      rs2_data,
    output logic                 stalled
);

    of_state_t       r_state;
    instructions     r_instr;
    logic            r_completed;
    logic            r_stalled;
    logic [XLEN-1:0] r_rs1Data;
    logic [XLEN-1:0] r_rs2Data;
    logic [NREGS-1:0] r_pendInt;
    logic [NREGS-1:0] r_pendFlt;

    instructions     w_curInstr;
    logic            w_intWe;
    logic            w_fltWe;
    logic [XLEN-1:0] w_int1, w_int2, w_flt1, w_flt2;
    logic [XLEN-1:0] w_rs1Val, w_rs2Val;
    logic            w_rs1Ready, w_rs2Ready, w_ready, w_issue;
    logic [NREGS-1:0] w_pendIntNext;
    logic [NREGS-1:0] w_pendFltNext;

    // The float strobe wins when both are raised
    assign w_fltWe = freg_w_enable;
    assign w_intWe = reg_w_enable && !freg_w_enable;

    // In IDLE the incoming request is evaluated directly; in WAIT the held one
    assign w_curInstr = (r_state == OF_IDLE) ? instr : r_instr;

    operand_fetch_regbank #(
        .NREGS(NREGS), .XLEN(XLEN), .ZERO_REG0(1'b1)
    ) uIntBank (
        .clk(clk), .rstn(rstn),
        .i_we(w_intWe), .i_waddr(reg_w_dest), .i_wdata(reg_w_data),
        .i_raddr1(w_curInstr.rs1), .i_raddr2(w_curInstr.rs2),
        .o_rdata1(w_int1), .o_rdata2(w_int2)
    );

    operand_fetch_regbank #(
        .NREGS(NREGS), .XLEN(XLEN), .ZERO_REG0(1'b0)
    ) uFltBank (
        .clk(clk), .rstn(rstn),
        .i_we(w_fltWe), .i_waddr(reg_w_dest), .i_wdata(reg_w_data),
        .i_raddr1(w_curInstr.rs1), .i_raddr2(w_curInstr.rs2),
        .o_rdata1(w_flt1), .o_rdata2(w_flt2)
    );

    // Source readiness: not pending, or being written this very cycle; x0 never waits
    always_comb begin
        if (w_curInstr.rs1_is_freg) begin
            w_rs1Ready = !r_pendFlt[w_curInstr.rs1] ||
                         (w_fltWe && (reg_w_dest == w_curInstr.rs1));
        end else begin
            w_rs1Ready = (w_curInstr.rs1 == '0) || !r_pendInt[w_curInstr.rs1] ||
                         (w_intWe && (reg_w_dest == w_curInstr.rs1));
        end
        if (w_curInstr.rs2_is_freg) begin
            w_rs2Ready = !r_pendFlt[w_curInstr.rs2] ||
                         (w_fltWe && (reg_w_dest == w_curInstr.rs2));
        end else begin
            w_rs2Ready = (w_curInstr.rs2 == '0) || !r_pendInt[w_curInstr.rs2] ||
                         (w_intWe && (reg_w_dest == w_curInstr.rs2));
        end
    end

    // Operand selection; identical sources share the rs1 lookup
    always_comb begin
        w_rs1Val = w_curInstr.rs1_is_freg ? w_flt1 : w_int1;
        w_rs2Val = w_curInstr.rs2_is_freg ? w_flt2 : w_int2;
        if ((w_curInstr.rs1 == w_curInstr.rs2) &&
            (w_curInstr.rs1_is_freg == w_curInstr.rs2_is_freg)) begin
            w_rs2Val = w_rs1Val;
        end
    end

    assign w_ready = w_rs1Ready && w_rs2Ready;
    assign w_issue = w_ready && ((r_state == OF_WAIT) || enabled);

    // Scoreboard next state: write-back clears first, a new producer then sets
    always_comb begin
        w_pendIntNext = r_pendInt;
        w_pendFltNext = r_pendFlt;
        if (w_intWe) w_pendIntNext[reg_w_dest] = 1'b0;
        if (w_fltWe) w_pendFltNext[reg_w_dest] = 1'b0;
        if (w_issue && w_curInstr.writes_rd) begin
            if (w_curInstr.writes_to_freg_as_rv32f) begin
                w_pendFltNext[w_curInstr.rd] = 1'b1;
            end else if (w_curInstr.rd != '0) begin
                w_pendIntNext[w_curInstr.rd] = 1'b1;
            end
        end
    end

    // Scoreboard registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pendInt <= '0;
            r_pendFlt <= '0;
        end else begin
            r_pendInt <= w_pendIntNext;
            r_pendFlt <= w_pendFltNext;
        end
    end

    // Fetch FSM with registered operand, completion and stall outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= OF_IDLE;
            r_instr     <= '0;
            r_completed <= 1'b0;
            r_stalled   <= 1'b0;
            r_rs1Data   <= '0;
            r_rs2Data   <= '0;
        end else begin
            case (r_state)
                OF_IDLE: begin
                    if (enabled) begin
                        r_instr <= instr;
                        if (w_ready) begin
                            r_rs1Data   <= w_rs1Val;
                            r_rs2Data   <= w_rs2Val;
                            r_completed <= 1'b1;
                        end else begin
                            r_completed <= 1'b0;
                            r_stalled   <= 1'b1;
                            r_state     <= OF_WAIT;
                        end
                    end
                end
                OF_WAIT: begin
                    if (w_ready) begin
                        r_rs1Data   <= w_rs1Val;
                        r_rs2Data   <= w_rs2Val;
                        r_completed <= 1'b1;
                        r_stalled   <= 1'b0;
                        r_state     <= OF_IDLE;
                    end
                end
                default: r_state <= OF_IDLE;
            endcase
        end
    end

    assign completed = r_completed;
    assign stalled   = r_stalled;
    assign rs1_data  = r_rs1Data;
    assign rs2_data  = r_rs2Data;

endmodule

// File: tb/tb_operand_fetch.sv
// Testbench for operand_fetch: directed scenarios with literal expectations
// plus a randomized producer, all cross-checked by a register-file model.
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enabled;
    instructions instr;
    logic        reg_w_enable, freg_w_enable;
    logic [4:0]  reg_w_dest;
    logic [31:0] reg_w_data;
    logic        completed, stalled;
    logic [31:0] rs1_data, rs2_data;

    int checks   = 0;
    int failures = 0;

    operand_fetch dut (
        .clk(clk), .rstn(rstn), .enabled(enabled), .instr(instr),
        .reg_w_enable(reg_w_enable), .freg_w_enable(freg_w_enable),
        .reg_w_dest(reg_w_dest), .reg_w_data(reg_w_data),
        .completed(completed), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .stalled(stalled)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Single comparison with reporting
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs from a negedge; returns at the following negedge
    task automatic applyStimulus(input logic en, input instructions ins, input logic iwe,
                                 input logic fwe, input logic [4:0] dest, input logic [31:0] data);
        enabled       = en;
        instr         = ins;
        reg_w_enable  = iwe;
        freg_w_enable = fwe;
        reg_w_dest    = dest;
        reg_w_data    = data;
        @(negedge clk);
    endtask

    function automatic instructions mkInstr(input logic [4:0] s1, input logic s1f,
                                            input logic [4:0] s2, input logic s2f,
                                            input logic [4:0] d, input logic df, input logic wrd);
        instructions t;
        t.rs1 = s1; t.rs1_is_freg = s1f;
        t.rs2 = s2; t.rs2_is_freg = s2f;
        t.rd  = d;  t.writes_to_freg_as_rv32f = df; t.writes_rd = wrd;
        return t;
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] mInt [32];
    logic [31:0] mFlt [32];
    bit          mPi  [32];
    bit          mPf  [32];
    bit          mBusy;
    instructions mHeld;
    logic [31:0] eRs1, eRs2;
    logic        eComp, eStall;

    function automatic bit mReady(input logic [4:0] idx, input logic isF, input bit wInt, input bit wFlt);
        if (isF) return !mPf[idx] || (wFlt && reg_w_dest == idx);
        if (idx == 5'd0) return 1'b1;
        return !mPi[idx] || (wInt && reg_w_dest == idx);
    endfunction

    function automatic logic [31:0] mValue(input logic [4:0] idx, input logic isF, input bit wInt, input bit wFlt);
        if (isF) return (wFlt && reg_w_dest == idx) ? reg_w_data : mFlt[idx];
        if (idx == 5'd0) return 32'h0;
        return (wInt && reg_w_dest == idx) ? reg_w_data : mInt[idx];
    endfunction

    // Model advances on every rising edge, then the DUT outputs are compared
    always @(posedge clk) begin : model
        instructions req;
        bit act, wInt, wFlt, issued;
        if (!rstn) begin
            for (int i = 0; i < 32; i++) begin
                mInt[i] = 32'h0; mFlt[i] = 32'h0; mPi[i] = 1'b0; mPf[i] = 1'b0;
            end
            mBusy = 1'b0; eRs1 = 32'h0; eRs2 = 32'h0; eComp = 1'b0; eStall = 1'b0;
        end else begin
            wFlt   = freg_w_enable;
            wInt   = reg_w_enable && !freg_w_enable;
            act    = mBusy || enabled;
            req    = mBusy ? mHeld : instr;
            issued = 1'b0;
            if (act) begin
                if (mReady(req.rs1, req.rs1_is_freg, wInt, wFlt) &&
                    mReady(req.rs2, req.rs2_is_freg, wInt, wFlt)) begin
                    eRs1   = mValue(req.rs1, req.rs1_is_freg, wInt, wFlt);
                    eRs2   = mValue(req.rs2, req.rs2_is_freg, wInt, wFlt);
                    eComp  = 1'b1;
                    eStall = 1'b0;
                    mBusy  = 1'b0;
                    issued = 1'b1;
                end else begin
                    eComp  = 1'b0;
                    eStall = 1'b1;
                    mBusy  = 1'b1;
                    mHeld  = req;
                end
            end
            if (wFlt) begin
                mFlt[reg_w_dest] = reg_w_data; mPf[reg_w_dest] = 1'b0;
            end else if (wInt && reg_w_dest != 5'd0) begin
                mInt[reg_w_dest] = reg_w_data; mPi[reg_w_dest] = 1'b0;
            end
            if (issued && req.writes_rd) begin
                if (req.writes_to_freg_as_rv32f) mPf[req.rd] = 1'b1;
                else if (req.rd != 5'd0)         mPi[req.rd] = 1'b1;
            end
        end
        #1;
        checkOutput("model_completed", {31'b0, completed}, {31'b0, eComp});
        checkOutput("model_stalled",   {31'b0, stalled},   {31'b0, eStall});
        if (eComp) begin
            checkOutput("model_rs1", rs1_data, eRs1);
            checkOutput("model_rs2", rs2_data, eRs2);
        end
    end

    // ---------------- stimulus ----------------
    instructions nop, cur;
    bit          reqActive;

    initial begin
        nop = mkInstr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        rstn = 1'b0;
        applyStimulus(1'b0, nop, 1'b0, 1'b0, 5'd0, 32'h0);
        applyStimulus(1'b0, nop, 1'b0, 1'b0, 5'd0, 32'h0);
        rstn = 1'b1;
        checkOutput("reset_completed", {31'b0, completed}, 32'h0);
        checkOutput("reset_stalled",   {31'b0, stalled},   32'h0);
        checkOutput("reset_rs1",       rs1_data,           32'h0);

        // T1: fresh registers read as zero with single-cycle latency
        applyStimulus(1'b1, mkInstr(5'd5, 1'b0, 5'd6, 1'b0, 5'd0, 1'b0, 1'b0), 1'b0, 1'b0, 5'd0, 32'h0);
        checkOutput("t1_completed", {31'b0, completed}, 32'h1);
        checkOutput("t1_stalled",   {31'b0, stalled},   32'h0);
        checkOutput("t1_rs1",       rs1_data,           32'h0);
        checkOutput("t1_rs2",       rs2_data,           32'h0);

        // T2: written value visible on a later fetch
        applyStimulus(1'b0, nop, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF);
        applyStimulus(1'b1, mkInstr(5'd5, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0), 1'b0, 1'b0, 5'd0, 32'h0);
        checkOutput("t2_completed", {31'b0, completed}, 32'h1);
        checkOutput("t2_rs1",       rs1_data,           32'hDEADBEEF);
        checkOutput("t2_rs2_same",  rs2_data,           32'hDEADBEEF);

        // T3: pending x7 stalls until write-back, then bypasses
        applyStimulus(1'b1, mkInstr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1), 1'b0, 1'b0, 5'd0, 32'h0);
        checkOutput("t3_issue", {31'b0, completed}, 32'h1);
        cur = mkInstr(5'd7, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, cur, 1'b0, 1'b0, 5'd0, 32'h0);
        checkOutput("t3_stalled",   {31'b0, stalled},   32'h1);
        checkOutput("t3_completed", {31'b0, completed}, 32'h0);
        applyStimulus(1'b1, cur, 1'b0, 1'b0, 5'd0, 32'h0);
        checkOutput("t3_still_stalled", {31'b0, stalled}, 32'h1);
        applyStimulus(1'b1, cur, 1'b1, 1'b0, 5'd7, 32'h1234);
        checkOutput("t3_done",      {31'b0, completed}, 32'h1);
        checkOutput("t3_unstalled", {31'b0, stalled},   32'h0);
        checkOutput("t3_rs1",       rs1_data,           32'h1234);
        checkOutput("t3_rs2",       rs2_data,           32'hDEADBEEF);

        // T4: x0 is never pending and ignores writes
        applyStimulus(1'b1, mkInstr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1), 1'b0, 1'b0, 5'd0, 32'h0);
        applyStimulus(1'b1, mkInstr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0), 1'b0, 1'b0, 5'd0, 32'h0);
        checkOutput("t4_no_stall", {31'b0, stalled},   32'h0);
        checkOutput("t4_done",     {31'b0, completed}, 32'h1);
        applyStimulus(1'b0, nop, 1'b1, 1'b0, 5'd0, 32'hFFFFFFFF);
        applyStimulus(1'b1, mkInstr(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0), 1'b0, 1'b0, 5'd0, 32'h0);
        checkOutput("t4_x0_zero", rs1_data, 32'h0);

        // T5: float f3 pending is not cleared by an int x3 write
        applyStimulus(1'b1, mkInstr(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1), 1'b0, 1'b0, 5'd0, 32'h0);
        applyStimulus(1'b0, nop, 1'b1, 1'b0, 5'd3, 32'h55);
        cur = mkInstr(5'd3, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, cur, 1'b0, 1'b0, 5'd0, 32'h0);
        checkOutput("t5_stalled", {31'b0, stalled}, 32'h1);
        applyStimulus(1'b1, cur, 1'b0, 1'b1, 5'd3, 32'h3F800000);
        checkOutput("t5_done",    {31'b0, completed}, 32'h1);
        checkOutput("t5_rs1_f3",  rs1_data,           32'h3F800000);
        checkOutput("t5_rs2_x3",  rs2_data,           32'h55);

        // T6: reset in WAIT drops the request and clears everything
        applyStimulus(1'b1, mkInstr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1), 1'b0, 1'b0, 5'd0, 32'h0);
        cur = mkInstr(5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, cur, 1'b0, 1'b0, 5'd0, 32'h0);
        checkOutput("t6_stalled", {31'b0, stalled}, 32'h1);
        rstn = 1'b0;
        applyStimulus(1'b1, cur, 1'b0, 1'b0, 5'd0, 32'h0);
        checkOutput("t6_rst_completed", {31'b0, completed}, 32'h0);
        checkOutput("t6_rst_stalled",   {31'b0, stalled},   32'h0);
        rstn = 1'b1;
        applyStimulus(1'b0, nop, 1'b0, 1'b0, 5'd0, 32'h0);
        applyStimulus(1'b1, cur, 1'b0, 1'b0, 5'd0, 32'h0);
        checkOutput("t6_after_completed", {31'b0, completed}, 32'h1);
        checkOutput("t6_after_stalled",   {31'b0, stalled},   32'h0);
        checkOutput("t6_after_rs1",       rs1_data,           32'h0);

        // Randomized producer honouring the hold-until-completed handshake
        reqActive = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (reqActive && completed) reqActive = 1'b0;
            if (!reqActive && ($urandom_range(0, 1) == 1)) begin
                cur = mkInstr(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                              5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                              5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)));
                reqActive = 1'b1;
            end
            applyStimulus(reqActive, cur, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                          5'($urandom_range(0, 7)), $urandom);
        end

        // Let any outstanding request finish within a bounded number of cycles
        for (int c = 0; c < 500; c++) begin
            if (reqActive && completed) reqActive = 1'b0;
            if (!reqActive) break;
            applyStimulus(1'b1, cur, ($urandom_range(0, 1) == 0), 1'b0,
                          5'($urandom_range(0, 7)), $urandom);
        end
        checks++;
        if (reqActive) begin
            failures++;
            $display("[TB] FAIL drain_timeout actual=stalled expected=completed");
        end
        applyStimulus(1'b0, nop, 1'b0, 1'b0, 5'd0, 32'h0);
        applyStimulus(1'b0, nop, 1'b0, 1'b0, 5'd0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
